// File: rtl/line_seq_pkg.sv
// Shared types and constants for the line sequencer and its command queue.
package line_seq_pkg;

  localparam int unsigned COORD_W = 11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDraw,
    StClear
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               color;
    logic               clr;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO of DEPTH packed commands with full/empty flags.
module line_cmd_fifo
  import line_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q];

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/line_sequencer.sv
// Line sequencer: queues line/clear commands and drives an external line
// engine and a frame-buffer write port. Define LINE_SEQ_CLEAR_EN to enable
// the clear-screen raster sweep; otherwise clear commands are discarded.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned X_MAX = 640,
  parameter int unsigned Y_MAX = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_color,
  input  logic               cmd_clr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [COORD_W-1:0] eng_x0,
  output logic [COORD_W-1:0] eng_y0,
  output logic [COORD_W-1:0] eng_x1,
  output logic [COORD_W-1:0] eng_y1,
  output logic               eng_reset,
  input  logic [COORD_W-1:0] eng_x,
  input  logic [COORD_W-1:0] eng_y,
  input  logic               eng_done,
  output logic               pix_we,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_color,
  output logic               busy
);

  state_t             state_q;
  state_t             state_d;
  cmd_t               wr_cmd;
  cmd_t               head;
  logic [CMD_W-1:0]   head_raw;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [COORD_W-1:0] cur_x0_q;
  logic [COORD_W-1:0] cur_y0_q;
  logic [COORD_W-1:0] cur_x1_q;
  logic [COORD_W-1:0] cur_y1_q;
  logic               cur_color_q;

`ifdef LINE_SEQ_CLEAR_EN
  localparam logic [COORD_W-1:0] XLast = COORD_W'(X_MAX - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(Y_MAX - 1);

  logic [COORD_W-1:0] ras_x_q;
  logic [COORD_W-1:0] ras_y_q;
  logic               ras_last;

  assign ras_last = (ras_x_q == XLast) && (ras_y_q == YLast);
`endif

  assign wr_cmd = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1,
                    color: cmd_color, clr: cmd_clr};
  assign head      = cmd_t'(head_raw);
  assign cmd_ready = ~full & ~reset;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == StIdle) & ~empty;

  line_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(wr_cmd),
    .pop  (pop),
    .rdata(head_raw),
    .full (full),
    .empty(empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
`ifdef LINE_SEQ_CLEAR_EN
          state_d = head.clr ? StClear : StLoad;
`else
          // Clear commands are dropped, costing one idle cycle.
          state_d = head.clr ? StIdle : StLoad;
`endif
        end
      end
      StLoad:  state_d = StDraw;
      StDraw:  if (eng_done) state_d = StIdle;
      StClear: begin
`ifdef LINE_SEQ_CLEAR_EN
        if (ras_last) state_d = StIdle;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Current-command register, updated on every pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x0_q    <= '0;
      cur_y0_q    <= '0;
      cur_x1_q    <= '0;
      cur_y1_q    <= '0;
      cur_color_q <= 1'b0;
    end else if (pop) begin
      cur_x0_q    <= head.x0;
      cur_y0_q    <= head.y0;
      cur_x1_q    <= head.x1;
      cur_y1_q    <= head.y1;
      cur_color_q <= head.color;
    end
  end

`ifdef LINE_SEQ_CLEAR_EN
  // Raster counters: x inner, y outer; they return to 0 after the last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_x_q <= '0;
      ras_y_q <= '0;
    end else if (state_q == StClear) begin
      if (ras_x_q == XLast) begin
        ras_x_q <= '0;
        ras_y_q <= (ras_y_q == YLast) ? '0 : ras_y_q + COORD_W'(1);
      end else begin
        ras_x_q <= ras_x_q + COORD_W'(1);
      end
    end
  end
`endif

  // Output decode.
  always_comb begin
    pix_we = 1'b0;
    pix_x  = '0;
    pix_y  = '0;
    unique case (state_q)
      StDraw: begin
        pix_we = ~eng_done;
        pix_x  = eng_x;
        pix_y  = eng_y;
      end
      StClear: begin
`ifdef LINE_SEQ_CLEAR_EN
        pix_we = 1'b1;
        pix_x  = ras_x_q;
        pix_y  = ras_y_q;
`endif
      end
      default: ;
    endcase
  end

  assign eng_reset = reset | (state_q == StLoad);
  assign eng_x0    = cur_x0_q;
  assign eng_y0    = cur_y0_q;
  assign eng_x1    = cur_x1_q;
  assign eng_y1    = cur_y1_q;
  assign pix_color = cur_color_q;
  assign busy      = ~reset & ((state_q != StIdle) | ~empty);

endmodule

// File: tb/tb_line_sequencer.sv
// Directed bench for line_sequencer with a simple stepping line-engine model.
module tb_line_sequencer;

  localparam int DEPTH = 4;
  localparam int XM    = 8;
  localparam int YM    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic        cmd_color, cmd_clr, cmd_valid, cmd_ready;
  logic [10:0] eng_x0, eng_y0, eng_x1, eng_y1;
  logic        eng_reset;
  logic [10:0] ex, ey;
  logic        edone;
  logic        pix_we, pix_color, busy;
  logic [10:0] pix_x, pix_y;

  int checks   = 0;
  int failures = 0;
  int rst_cycles;
  int n;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        c;
  } wr_t;
  wr_t log_q[$];

  always #5 clk = ~clk;

  line_sequencer #(
    .DEPTH(DEPTH),
    .X_MAX(XM),
    .Y_MAX(YM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_x1   (cmd_x1),
    .cmd_y1   (cmd_y1),
    .cmd_color(cmd_color),
    .cmd_clr  (cmd_clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .eng_x0   (eng_x0),
    .eng_y0   (eng_y0),
    .eng_x1   (eng_x1),
    .eng_y1   (eng_y1),
    .eng_reset(eng_reset),
    .eng_x    (ex),
    .eng_y    (ey),
    .eng_done (edone),
    .pix_we   (pix_we),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color),
    .busy     (busy)
  );

  // Engine model: emits x0,y0 first, steps one pixel per cycle toward x1,y1,
  // and raises done the cycle after the last pixel.
  always @(posedge clk) begin
    if (eng_reset) begin
      ex    <= eng_x0;
      ey    <= eng_y0;
      edone <= 1'b0;
    end else if (!edone) begin
      if (ex == eng_x1 && ey == eng_y1) begin
        edone <= 1'b1;
      end else begin
        if (ex < eng_x1)      ex <= ex + 11'd1;
        else if (ex > eng_x1) ex <= ex - 11'd1;
        if (ey < eng_y1)      ey <= ey + 11'd1;
        else if (ey > eng_y1) ey <= ey - 11'd1;
      end
    end
  end

  // Write log and engine-restart counter.
  always @(negedge clk) begin
    if (pix_we) log_q.push_back({pix_x, pix_y, pix_color});
    if (eng_reset && !reset) rst_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic color, input logic clr);
    cmd_x0    = 11'(x0);
    cmd_y0    = 11'(y0);
    cmd_x1    = 11'(x1);
    cmd_y1    = 11'(y1);
    cmd_color = color;
    cmd_clr   = clr;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check(tag, busy, 0);
    step();
  endtask

  task automatic check_wr(input string tag, input int idx, input int x, input int y,
                          input int c);
    if (idx < log_q.size()) begin
      check({tag, "_x"}, log_q[idx].x, x);
      check({tag, "_y"}, log_q[idx].y, y);
      check({tag, "_c"}, log_q[idx].c, c);
    end else begin
      check({tag, "_missing"}, idx, log_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_clr = 1'b0; cmd_color = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    rst_cycles = 0;
    repeat (2) step();

    // Reset state.
    @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_we", pix_we, 0);
    check("rst_engrst", eng_reset, 1);
    check("rst_pixx", pix_x, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    step();

    // Latency and horizontal line.
    log_q.delete(); rst_cycles = 0;
    push_cmd(10, 100, 25, 100, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_n1_engrst", eng_reset, 0);
    check("lat_n1_busy", busy, 1);
    @(negedge clk);
    check("lat_n2_engrst", eng_reset, 1);
    check("lat_n2_we", pix_we, 0);
    @(negedge clk);
    check("lat_n3_we", pix_we, 1);
    check("lat_n3_x", pix_x, 10);
    check("lat_n3_color", pix_color, 1);
    wait_idle("hline_idle");
    check("hline_count", log_q.size(), 16);
    for (int i = 0; i < 16; i++) check_wr("hline", i, 10 + i, 100, 1);
    check("hline_engrst_cycles", rst_cycles, 1);

    // Steep line.
    log_q.delete(); rst_cycles = 0;
    push_cmd(100, 20, 100, 30, 1'b0, 1'b0);
    wait_idle("steep_idle");
    check("steep_count", log_q.size(), 11);
    for (int i = 0; i < 11; i++) check_wr("steep", i, 100, 20 + i, 0);
    check("steep_engrst_cycles", rst_cycles, 1);

    // Back-pressure during a long draw.
    log_q.delete();
    push_cmd(0, 0, 199, 0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !pix_we; i++) @(negedge clk);
    check("bp_started", pix_we, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      cmd_x0 = 11'(i * 10); cmd_y0 = 11'd50;
      cmd_x1 = 11'(i * 10 + 2); cmd_y1 = 11'd50;
      cmd_color = i[0]; cmd_clr = 1'b0; cmd_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_ready_%0d", i), cmd_ready, (i < 4) ? 1 : 0);
      step();
    end
    cmd_valid = 1'b0;
    wait_idle("bp_idle");
    check("bp_count", log_q.size(), 200 + 4 * 3);
    for (int i = 0; i < 200; i++) check_wr("bp_long", i, i, 0, 1);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) check_wr("bp_short", 200 + k * 3 + j, k * 10 + j, 50, k % 2);

    // Clear command followed by a normal line.
    log_q.delete();
    push_cmd(0, 0, 0, 0, 1'b1, 1'b1);
    push_cmd(5, 5, 6, 5, 1'b0, 1'b0);
    wait_idle("clr_idle");
`ifdef LINE_SEQ_CLEAR_EN
    check("clr_count", log_q.size(), XM * YM + 2);
    for (int i = 0; i < XM * YM; i++) check_wr("clr_ras", i, i % XM, i / XM, 1);
    check_wr("clr_line0", XM * YM, 5, 5, 0);
    check_wr("clr_line1", XM * YM + 1, 6, 5, 0);
`else
    check("clr_count", log_q.size(), 2);
    check_wr("clr_line0", 0, 5, 5, 0);
    check_wr("clr_line1", 1, 6, 5, 0);
`endif

    // Reset on the 5th write of a line, with another command queued.
    log_q.delete();
    push_cmd(10, 100, 25, 100, 1'b1, 1'b0);
    push_cmd(1, 1, 3, 1, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (pix_we) n++;
    end
    check("mid_reached5", n, 5);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mid_we_after", pix_we, 0);
    check("mid_ready_in_rst", cmd_ready, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_we", pix_we, 0);
    check("mid_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    check("mid_count", log_q.size(), 5);
    check("mid_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_sequencer.md
LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 Parameter DEPTH, 4, command queue entries (power of two, >=2).
REQ-002 Parameter X_MAX, 640, clear-sweep width in pixels.
REQ-003 Parameter Y_MAX, 480, clear-sweep height in pixels.
REQ-004 Port clk  in  1  sole clock; all state on posedge clk.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  11 each  line endpoint coordinates.
REQ-007 Port cmd_color  in  1  pixel colour for the command.
REQ-008 Port cmd_clr  in  1  1 = clear-screen command; coordinates are ignored.
REQ-009 Port cmd_valid  in  1 / cmd_ready  out  1  push handshake; push occurs on an edge where both are 1.
REQ-010 Ports eng_x0, eng_y0, eng_x1, eng_y1  out  11 each  endpoints driven to the line engine.
REQ-011 Port eng_reset  out  1  engine restart strobe.
REQ-012 Ports eng_x, eng_y  in  11 each / eng_done  in  1  engine pixel and completion flag.
REQ-013 Ports pix_we  out  1, pix_x, pix_y  out  11, pix_color  out  1  frame-buffer write.
REQ-014 Port busy  out  1  high when state != IDLE or the queue is non-empty.

Function
REQ-015 Commands SHALL be queued in FIFO order; cmd_ready = !full & !reset; a push while full is impossible, and a pop on the same edge does not free a slot for that edge.
REQ-016 Push and pop on the same edge (queue neither empty nor full) SHALL both take effect; occupancy is unchanged.
REQ-017 The FSM SHALL have the states IDLE, LOAD, DRAW and CLEAR.
REQ-018 IDLE SHALL pop the head entry when the queue is non-empty and latch it into a current-command register; next state is CLEAR if cmd_clr is set and clear is enabled, otherwise LOAD.
REQ-019 LOAD SHALL last exactly one cycle with eng_reset=1; next state is DRAW.
REQ-020 eng_x0..eng_y1 SHALL hold the latched command from LOAD until the next pop, including through DRAW.
REQ-021 DRAW SHALL assert pix_we = !eng_done, with pix_x=eng_x and pix_y=eng_y; on the first cycle with eng_done=1 the next state is IDLE.
REQ-022 A single-pixel line (engine done one cycle after LOAD) SHALL produce exactly one write.
REQ-023 CLEAR SHALL sweep x from 0 to X_MAX-1 inner and y from 0 to Y_MAX-1 outer, one write per cycle with pix_we=1, for exactly X_MAX*Y_MAX writes, then go to IDLE.
REQ-024 Latency: a push at edge N into an empty, idle block gives eng_reset=1 in cycle N+2 and the first pix_we in cycle N+3.
REQ-025 pix_color SHALL equal the latched cmd_color; pix_x, pix_y and pix_we SHALL be 0 outside DRAW and CLEAR.
REQ-026 eng_reset = reset | (state==LOAD).
REQ-027 The raster counters SHALL be 11 bits, unsigned, with no wrap beyond X_MAX-1 or Y_MAX-1.

Reset
REQ-028 Reset SHALL take the state to IDLE, empty the queue, clear the counters and the latched command to 0, and drive pix_we=0, busy=0 and cmd_ready=0.
REQ-029 Reset mid-DRAW or mid-CLEAR SHALL abort with no further writes from the next cycle; queued commands are discarded.

Configuration
REQ-030 With macro LINE_SEQ_CLEAR_EN defined, the CLEAR state and raster counters SHALL exist.
REQ-031 Without LINE_SEQ_CLEAR_EN, a popped command with cmd_clr=1 SHALL be discarded: IDLE to IDLE, no writes, one cycle consumed; the raster counters are absent.

Structure
REQ-032 Package line_seq_pkg SHALL hold COORD_W=11, the state enum and the packed cmd struct {x0,y0,x1,y1,color,clr}.
REQ-033 The queue SHALL be a sub-module line_cmd_fifo (DEPTH x cmd struct, synchronous, full/empty flags).
REQ-034 The line engine is instantiated outside this block and connected through the eng_* ports.

Verification
REQ-035 Horizontal line: push (10,100)->(25,100), colour 1, with the real engine attached -> 16 writes, x 10..25, y=100, then busy=0.
REQ-036 Steep line: push (100,20)->(100,30) -> 11 writes, y 20..30, x=100; eng_reset high exactly 1 cycle.
REQ-037 Back-pressure, DEPTH=4: 6 back-to-back pushes during a long draw -> cmd_ready falls after 4 queued; all accepted lines drawn in order with no lost or duplicated writes.
REQ-038 Clear with the macro and X_MAX=8, Y_MAX=4 -> 32 consecutive writes, raster order, last at (7,3); without the macro -> 0 writes, next command starts normally.
REQ-039 Reset asserted on the 5th write of the (10,100)->(25,100) line -> pix_we=0 from the next cycle, queue empty, state IDLE.
REQ-040 Latency check: a single push into the idle block -> eng_reset in cycle N+2 and first pix_we in cycle N+3.
